// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for one single-port word memory shared by data (d), fetch (i) and DMA (x, only with MEM_ARB_DMA_EN).
// Latency: gnt in cycle N, memory access in N+1..N+WAIT_CYCLES, rvalid in N+WAIT_CYCLES+1.
// Backpressure: one access in flight; requesters hold req until gnt, and stall_if/stall_mem freeze the pipeline meanwhile.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_wdata,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_D = 2'd0, OWN_I = 2'd1, OWN_X = 2'd2} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wait_cnt_q, wait_cnt_d;
  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   rd_val;
  logic                arb_en, i_first, d_win, i_win;
`ifdef MEM_ARB_DMA_EN
  logic [DATA_W-1:0]   x_rdata_q, x_rdata_d;
  logic                x_win;
`else
  logic                unused_x;
  assign unused_x = ^{x_req, x_we, x_addr, x_wdata};
`endif

  // Grants are combinational so a request can win in the same cycle; none while in reset.
  assign arb_en  = (state_q != ACCESS) && !reset;
  assign i_first = i_req && (starve_cnt_q == STARVE_MAX);
  assign d_win   = arb_en && d_req && !i_first;
  assign i_win   = arb_en && i_req && (i_first || !d_req);
`ifdef MEM_ARB_DMA_EN
  assign x_win   = arb_en && x_req && !d_req && !i_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wait_cnt_d   = wait_cnt_q;
    d_rdata_d    = d_rdata_q;
    i_rdata_d    = i_rdata_q;
`ifdef MEM_ARB_DMA_EN
    x_rdata_d    = x_rdata_q;
`endif
    rd_val       = we_q ? '0 : mem_rdata;
    case (state_q)
      ACCESS: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = RESP;
          case (owner_q)
            OWN_D:   d_rdata_d = rd_val;
            OWN_I:   i_rdata_d = rd_val;
`ifdef MEM_ARB_DMA_EN
            OWN_X:   x_rdata_d = rd_val;
`endif
            default: ;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (d_win) begin
          state_d    = ACCESS;
          owner_d    = OWN_D;
          we_d       = d_we;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          wait_cnt_d = WAIT_LOAD;
        end else if (i_win) begin
          state_d    = ACCESS;
          owner_d    = OWN_I;
          we_d       = 1'b0;
          addr_d     = i_addr;
          wait_cnt_d = WAIT_LOAD;
`ifdef MEM_ARB_DMA_EN
        end else if (x_win) begin
          state_d    = ACCESS;
          owner_d    = OWN_X;
          we_d       = x_we;
          addr_d     = x_addr;
          wdata_d    = x_wdata;
          wait_cnt_d = WAIT_LOAD;
`endif
        end
      end
    endcase

    starve_cnt_d = starve_cnt_q;
    if (!i_req || i_win) begin
      starve_cnt_d = 4'd0;
    end else if (d_win && (starve_cnt_q != STARVE_MAX)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_D;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= 4'd0;
      starve_cnt_q <= 4'd0;
      d_rdata_q    <= '0;
      i_rdata_q    <= '0;
`ifdef MEM_ARB_DMA_EN
      x_rdata_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      d_rdata_q    <= d_rdata_d;
      i_rdata_q    <= i_rdata_d;
`ifdef MEM_ARB_DMA_EN
      x_rdata_q    <= x_rdata_d;
`endif
    end
  end

  // Strobes are masked during reset so an aborted write can never commit on the reset edge.
  assign mem_en    = (state_q == ACCESS) && !reset;
  assign mem_we    = mem_en && we_q && (wait_cnt_q == 4'd0);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);

  assign d_gnt     = d_win;
  assign i_gnt     = i_win;
  assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D) && !reset;
  assign i_rvalid  = (state_q == RESP) && (owner_q == OWN_I) && !reset;
  assign d_rdata   = d_rdata_q;
  assign i_rdata   = i_rdata_q;
`ifdef MEM_ARB_DMA_EN
  assign x_gnt     = x_win;
  assign x_rvalid  = (state_q == RESP) && (owner_q == OWN_X) && !reset;
  assign x_rdata   = x_rdata_q;
`else
  assign x_gnt     = 1'b0;
  assign x_rvalid  = 1'b0;
  assign x_rdata   = '0;
`endif

  assign stall_if  = i_req && !i_rvalid;
  assign stall_mem = d_req && !d_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (WAIT 1/STARVE 2 and WAIT 4/STARVE 4), each with its own memory and reference model.
module tb_mem_port_arbiter;

  localparam int L_DGNT = 1, L_IGNT = 2, L_XGNT = 3, L_DRV = 4, L_IRV = 5, L_XRV = 6, L_DRD = 7;
  localparam int L_IRD = 8, L_XRD = 9, L_MEN = 10, L_MWE = 11, L_MADDR = 12, L_STIF = 13, L_BUSY = 14;

  logic clk;
  logic reset [2];
  logic d_req [2], d_we [2], i_req [2], x_req [2], x_we [2];
  logic [31:0] d_addr [2], d_wdata [2], i_addr [2], x_addr [2], x_wdata [2];
  logic d_gnt [2], d_rvalid [2], i_gnt [2], i_rvalid [2], x_gnt [2], x_rvalid [2];
  logic [31:0] d_rdata [2], i_rdata [2], x_rdata [2];
  logic mem_en [2], mem_we [2], stall_if [2], stall_mem [2], busy [2];
  logic [31:0] mem_addr [2], mem_wdata [2], mem_rdata [2];
  logic [31:0] mem [2][256];

  // Reference model: remaining access cycles, pending response owner (1=d 2=i 3=x), latched request, per-owner read data.
  int rem [2], resp [2], own_m [2], starve [2];
  logic we_m [2];
  logic [31:0] addr_m [2], wd_m [2];
  logic [31:0] rd_m [2][3];
  logic [31:0] mm [2][256];

  int checks = 0, errors = 0, cyc = 0;
  logic chk_en = 1'b0;
  int lit_n = 0;
  int lit_k [8], lit_sel [8];
  logic [31:0] lit_val [8];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1), .STARVE_LIMIT(2)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_gnt(i_gnt[0]), .i_rvalid(i_rvalid[0]), .i_rdata(i_rdata[0]),
    .x_req(x_req[0]), .x_we(x_we[0]), .x_addr(x_addr[0]), .x_wdata(x_wdata[0]),
    .x_gnt(x_gnt[0]), .x_rvalid(x_rvalid[0]), .x_rdata(x_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .stall_if(stall_if[0]), .stall_mem(stall_mem[0]), .busy(busy[0]));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_gnt(i_gnt[1]), .i_rvalid(i_rvalid[1]), .i_rdata(i_rdata[1]),
    .x_req(x_req[1]), .x_we(x_we[1]), .x_addr(x_addr[1]), .x_wdata(x_wdata[1]),
    .x_gnt(x_gnt[1]), .x_rvalid(x_rvalid[1]), .x_rdata(x_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .stall_if(stall_if[1]), .stall_mem(stall_mem[1]), .busy(busy[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata[0] = mem[0][mem_addr[0][7:0]];
  assign mem_rdata[1] = mem[1][mem_addr[1][7:0]];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
  end

  function automatic int wc(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic int lim(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  // Who the rules say wins this cycle (0 = nobody).
  function automatic int pick(input int k);
    if (reset[k] || rem[k] != 0) return 0;
    if (i_req[k] && starve[k] == lim(k)) return 2;
    if (d_req[k]) return 1;
    if (i_req[k]) return 2;
`ifdef MEM_ARB_DMA_EN
    if (x_req[k]) return 3;
`endif
    return 0;
  endfunction

  function automatic logic exp_rv(input int k, input int o);
    return !reset[k] && resp[k] == o;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset[k]) begin
        rem[k] <= 0; resp[k] <= 0; own_m[k] <= 0; starve[k] <= 0;
        we_m[k] <= 1'b0; addr_m[k] <= '0; wd_m[k] <= '0;
        for (int j = 0; j < 3; j++) rd_m[k][j] <= '0;
      end else begin
        if (rem[k] == 1) begin
          resp[k] <= own_m[k];
          if (we_m[k]) mm[k][addr_m[k][7:0]] <= wd_m[k];
          rd_m[k][own_m[k]-1] <= we_m[k] ? 32'h0 : mm[k][addr_m[k][7:0]];
        end else begin
          resp[k] <= 0;
        end
        if (!i_req[k] || pick(k) == 2) starve[k] <= 0;
        else if (pick(k) == 1 && starve[k] < lim(k)) starve[k] <= starve[k] + 1;
        if (pick(k) == 1) begin
          own_m[k] <= 1; we_m[k] <= d_we[k]; addr_m[k] <= d_addr[k]; wd_m[k] <= d_wdata[k]; rem[k] <= wc(k);
        end else if (pick(k) == 2) begin
          own_m[k] <= 2; we_m[k] <= 1'b0; addr_m[k] <= i_addr[k]; rem[k] <= wc(k);
        end else if (pick(k) == 3) begin
          own_m[k] <= 3; we_m[k] <= x_we[k]; addr_m[k] <= x_addr[k]; wd_m[k] <= x_wdata[k]; rem[k] <= wc(k);
        end else if (rem[k] > 0) begin
          rem[k] <= rem[k] - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] act_of(input int k, input int sel);
    case (sel)
      L_DGNT:  return 32'(d_gnt[k]);
      L_IGNT:  return 32'(i_gnt[k]);
      L_XGNT:  return 32'(x_gnt[k]);
      L_DRV:   return 32'(d_rvalid[k]);
      L_IRV:   return 32'(i_rvalid[k]);
      L_XRV:   return 32'(x_rvalid[k]);
      L_DRD:   return d_rdata[k];
      L_IRD:   return i_rdata[k];
      L_XRD:   return x_rdata[k];
      L_MEN:   return 32'(mem_en[k]);
      L_MWE:   return 32'(mem_we[k]);
      L_MADDR: return mem_addr[k];
      L_STIF:  return 32'(stall_if[k]);
      default: return 32'(busy[k]);
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk("d_gnt", k, 32'(d_gnt[k]), 32'(pick(k) == 1));
        chk("i_gnt", k, 32'(i_gnt[k]), 32'(pick(k) == 2));
        chk("x_gnt", k, 32'(x_gnt[k]), 32'(pick(k) == 3));
        chk("d_rvalid", k, 32'(d_rvalid[k]), 32'(exp_rv(k, 1)));
        chk("i_rvalid", k, 32'(i_rvalid[k]), 32'(exp_rv(k, 2)));
        chk("x_rvalid", k, 32'(x_rvalid[k]), 32'(exp_rv(k, 3)));
        chk("d_rdata", k, d_rdata[k], rd_m[k][0]);
        chk("i_rdata", k, i_rdata[k], rd_m[k][1]);
        chk("x_rdata", k, x_rdata[k], rd_m[k][2]);
        chk("mem_en", k, 32'(mem_en[k]), 32'(!reset[k] && rem[k] != 0));
        chk("mem_we", k, 32'(mem_we[k]), 32'(!reset[k] && rem[k] == 1 && we_m[k]));
        chk("mem_addr", k, mem_addr[k], addr_m[k]);
        chk("mem_wdata", k, mem_wdata[k], wd_m[k]);
        chk("stall_if", k, 32'(stall_if[k]), 32'(i_req[k] && !exp_rv(k, 2)));
        chk("stall_mem", k, 32'(stall_mem[k]), 32'(d_req[k] && !exp_rv(k, 1)));
        chk("busy", k, 32'(busy[k]), 32'(rem[k] != 0 || resp[k] != 0));
      end
      for (int n = 0; n < lit_n; n++)
        chk("literal", lit_k[n], act_of(lit_k[n], lit_sel[n]), lit_val[n]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    lit_n = 0;
    cyc = cyc + 1;
  endtask

  task automatic lit(input int k, input int sel, input logic [31:0] v);
    if (lit_n < 8) begin
      lit_k[lit_n] = k;
      lit_sel[lit_n] = sel;
      lit_val[lit_n] = v;
      lit_n++;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 256; a++) begin
        mem[k][a] = {16'hC0DE, 8'h00, 8'(a)};
        mm[k][a]  = {16'hC0DE, 8'h00, 8'(a)};
      end
      mem[k][8'h10] = 32'h2002_0005;
      mm[k][8'h10]  = 32'h2002_0005;
      reset[k] = 1'b1;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      i_req[k] = 1'b0; i_addr[k] = '0;
      x_req[k] = 1'b0; x_we[k] = 1'b0; x_addr[k] = '0; x_wdata[k] = '0;
    end
    i_req[0] = 1'b1;
    // Reset cycle: no grant, stall_if still follows i_req.
    tick();
    chk_en = 1'b1;
    lit(0, L_STIF, 1); lit(0, L_IGNT, 0); lit(0, L_BUSY, 0); lit(1, L_MEN, 0);
    tick();
    reset[0] = 1'b0; reset[1] = 1'b0; i_req[0] = 1'b0;
    tick();

    // Single fetch.
    tick(); i_req[0] = 1'b1; i_addr[0] = 32'h10;
    lit(0, L_IGNT, 1); lit(0, L_STIF, 1); lit(0, L_BUSY, 0);
    tick(); lit(0, L_MEN, 1); lit(0, L_MADDR, 32'h10); lit(0, L_STIF, 1);
    tick(); i_req[0] = 1'b0;
    lit(0, L_IRV, 1); lit(0, L_IRD, 32'h2002_0005); lit(0, L_STIF, 0); lit(0, L_BUSY, 1);
    tick();

    // Data write and fetch together.
    tick(); d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'hDEAD_BEEF;
    i_req[0] = 1'b1; i_addr[0] = 32'h11;
    lit(0, L_DGNT, 1); lit(0, L_IGNT, 0);
    tick(); d_req[0] = 1'b0; d_we[0] = 1'b0; lit(0, L_MWE, 1); lit(0, L_MADDR, 32'h40);
    tick(); lit(0, L_DRV, 1); lit(0, L_IGNT, 1);
    tick(); lit(0, L_MWE, 0);
    tick(); i_req[0] = 1'b0; lit(0, L_IRV, 1); lit(0, L_IRD, 32'hC0DE_0011);
    tick();

    // Starvation: d, d, i, d, d, i.
    for (int c = 0; c < 12; c++) begin
      tick();
      if (c == 0) begin
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h40;
        i_req[0] = 1'b1; i_addr[0] = 32'h20;
      end
      if (c == 0 || c == 2 || c == 6 || c == 8) lit(0, L_DGNT, 1);
      if (c == 4 || c == 10) lit(0, L_IGNT, 1);
      if (c == 2) lit(0, L_DRD, 32'hDEAD_BEEF);
    end
    tick(); d_req[0] = 1'b0; i_req[0] = 1'b0; lit(0, L_IRV, 1); lit(0, L_IRD, 32'hC0DE_0020);
    tick();

    // DMA requester alone, then behind a data request.
    tick(); x_req[0] = 1'b1; x_addr[0] = 32'h30;
`ifdef MEM_ARB_DMA_EN
    lit(0, L_XGNT, 1);
`else
    lit(0, L_XGNT, 0);
`endif
    tick(); x_req[0] = 1'b0;
    tick();
`ifdef MEM_ARB_DMA_EN
    lit(0, L_XRV, 1); lit(0, L_XRD, 32'hC0DE_0030);
`else
    lit(0, L_XRV, 0); lit(0, L_BUSY, 0);
`endif
    tick(); d_req[0] = 1'b1; d_addr[0] = 32'h10; x_req[0] = 1'b1; x_addr[0] = 32'h31;
    lit(0, L_DGNT, 1); lit(0, L_XGNT, 0);
    tick(); d_req[0] = 1'b0;
    tick(); lit(0, L_DRV, 1); lit(0, L_DRD, 32'h2002_0005);
`ifdef MEM_ARB_DMA_EN
    lit(0, L_XGNT, 1);
`else
    lit(0, L_XGNT, 0);
`endif
    tick(); x_req[0] = 1'b0;
    tick();
`ifdef MEM_ARB_DMA_EN
    lit(0, L_XRV, 1); lit(0, L_XRD, 32'hC0DE_0031);
`else
    lit(0, L_XRD, 0);
`endif
    tick();

    // Reset in the 2nd access cycle of a 4-cycle write.
    tick(); d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h50; d_wdata[1] = 32'h5555_AAAA;
    lit(1, L_DGNT, 1);
    tick(); d_req[1] = 1'b0; d_we[1] = 1'b0; lit(1, L_MEN, 1); lit(1, L_MWE, 0);
    tick(); reset[1] = 1'b1; lit(1, L_MWE, 0); lit(1, L_BUSY, 1);
    tick(); reset[1] = 1'b0; lit(1, L_BUSY, 0); lit(1, L_MEN, 0);
    tick(); lit(1, L_DRV, 0);
    tick();

    // Read back the aborted address, then a full 4-cycle write and its read-back.
    tick(); d_req[1] = 1'b1; d_addr[1] = 32'h50; lit(1, L_DGNT, 1);
    tick(); d_req[1] = 1'b0;
    tick(); tick(); tick();
    tick(); lit(1, L_DRV, 1); lit(1, L_DRD, 32'hC0DE_0050);
    tick(); d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 32'h51; d_wdata[1] = 32'h1234_5678;
    lit(1, L_DGNT, 1);
    tick(); d_req[1] = 1'b0; d_we[1] = 1'b0; lit(1, L_MWE, 0);
    tick();
    tick(); lit(1, L_MWE, 0);
    tick(); lit(1, L_MWE, 1); lit(1, L_MADDR, 32'h51);
    tick(); lit(1, L_DRV, 1); lit(1, L_DRD, 32'h0);
    tick(); d_req[1] = 1'b1; d_addr[1] = 32'h51;
    tick(); d_req[1] = 1'b0;
    tick(); tick(); tick();
    tick(); lit(1, L_DRV, 1); lit(1, L_DRD, 32'h1234_5678);
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
